snoop_flush_tx: RTL

Per-cache transmitter for the shared 12-bit snooping data bus. It accepts flush/reply words from its cache controller, queues them, and drives them onto the cache's bus lane toward the data-bus arbiter. It watches the arbiter's output to detect when it has been granted, holds the word for a fixed number of granted cycles, and reports completion. One instance sits between each cache controller and its input to the data-bus arbiter.

---
 rtl/snoop_flush_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/snoop_flush_tx.sv
// snoop_flush_tx
//   Per-cache transmitter for the shared 12-bit snooping data bus. Queues
//   flush/reply words from the cache controller, drives the head word onto
//   this cache's lane toward the data-bus arbiter, detects grant by
//   comparing the arbiter output with our own lane, holds the word for
//   HOLD_CYCLES consecutive granted cycles and then pulses done.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   controller offers a word
//   req_ready  out  FIFO has room (count < DEPTH)
//   req_op     in   2-bit message type (00 is discarded)
//   req_addr   in   4-bit block address
//   req_data   in   4-bit data nibble
//   bus_in     in   arbiter output, as seen by every cache
//   bus_tx     out  this cache's lane to the arbiter (registered)
//   done       out  one-cycle pulse when the head word completes (registered)
//   done_addr  out  address of the completed word (registered)
//   starve     out  head word has waited MAX_WAIT ungranted cycles (registered)
module snoop_flush_tx #(
  parameter int DEPTH       = 2,
  parameter int HOLD_CYCLES = 2,
  parameter int MAX_WAIT    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [3:0]  req_addr,
  input  logic [3:0]  req_data,
  input  logic [11:0] bus_in,
  output logic [11:0] bus_tx,
  output logic        done,
  output logic [3:0]  done_addr,
  output logic        starve
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [9:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [11:0]   bus_tx_q, bus_tx_d;
  logic          done_q, done_d;
  logic [3:0]    done_addr_q, done_addr_d;
  logic          starve_q, starve_d;
  logic [7:0]    wait_q, wait_d;
  logic [3:0]    hold_q, hold_d;
  logic          push, finish, granted;
  logic [9:0]    head;

  // Ready depends only on occupancy; a pop in the same cycle does not
  // open a slot early.
  assign req_ready = (count_q < CW'(DEPTH));
  // Op 00 is handshaken but never stored.
  assign push      = req_valid && req_ready && (req_op != 2'b00);
  assign head      = mem_q[rd_ptr_q];
  // The arbiter forwards the winning lane, so seeing our own word on the
  // bus means we own it this cycle.
  assign granted   = (state_q != IDLE) && (bus_in == bus_tx_q);

  assign bus_tx    = bus_tx_q;
  assign done      = done_q;
  assign done_addr = done_addr_q;
  assign starve    = starve_q;

  // Storage carries no reset: contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_op, req_addr, req_data};
  end

  always_comb begin
    state_d     = state_q;
    bus_tx_d    = bus_tx_q;
    done_d      = 1'b0;
    done_addr_d = done_addr_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    hold_d      = hold_q;
    finish      = 1'b0;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (count_q != '0) begin
          bus_tx_d = {2'b01, head};
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (granted) begin
          hold_d   = 4'd1;
          wait_d   = '0;
          starve_d = 1'b0;
          if (HOLD_CYCLES == 1) finish = 1'b1;
          else                  state_d = HOLD;
        end else begin
          if (wait_q < 8'(MAX_WAIT)) wait_d = wait_q + 8'd1;
          if (wait_d == 8'(MAX_WAIT)) starve_d = 1'b1;
        end
      end
      HOLD: begin
        if (granted) begin
          hold_d = hold_q + 4'd1;
          if (hold_d == 4'(HOLD_CYCLES)) finish = 1'b1;
        end else begin
          // Preempted: the granted run must start over from scratch.
          state_d = DRIVE;
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (finish) begin
      done_d      = 1'b1;
      done_addr_d = head[7:4];
      bus_tx_d    = '0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bus_tx_q    <= '0;
      done_q      <= 1'b0;
      done_addr_q <= '0;
      starve_q    <= 1'b0;
      wait_q      <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      bus_tx_q    <= bus_tx_d;
      done_q      <= done_d;
      done_addr_q <= done_addr_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      hold_q      <= hold_d;
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push)   wr_ptr_q <= wr_ptr_q + PW'(1);
      if (finish) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, finish})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
